// File: rtl/shiftright_sticky_division.sv
// shiftright_sticky_division: multi-cycle right-shift denormalizer for the divider mantissa.
// Applies one binary shift stage per clock and collects guard, round and sticky bits.
module shiftright_sticky_division #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   nshiftright,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             guard,
    output logic             round,
    output logic             sticky
);
    localparam int EW = WIDTH + 2;
    localparam int CW = $clog2(SHW);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    ext_q, ext_d, ext_sh;
    logic [SHW-1:0]   amt_q, amt_d, sh;
    logic [CW-1:0]    stage_q, stage_d, k;
    logic             acc_q, acc_d, lost;
    logic [WIDTH-1:0] out_q, out_d;
    logic             guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;

    // Stages run from the largest power of two down to 1; a clear amount bit is a pass-through.
    assign k      = CW'(SHW - 1) - stage_q;
    assign sh     = amt_q[k] ? SHW'(1) << k : '0;
    assign ext_sh = ext_q >> sh;
    assign lost   = |(ext_q & ~({EW{1'b1}} << sh));

    always_comb begin
        state_d     = state_q;
        ext_d       = ext_q;
        amt_d       = amt_q;
        stage_d     = stage_q;
        acc_d       = acc_q;
        out_d       = out_q;
        guard_d     = guard_q;
        round_d     = round_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = SHIFT;
                ext_d   = {in, 2'b00};
                amt_d   = nshiftright;
                acc_d   = 1'b0;
                stage_d = '0;
            end
            SHIFT: begin
                ext_d   = ext_sh;
                acc_d   = acc_q | lost;
                stage_d = stage_q + CW'(1);
                if (stage_q == CW'(SHW - 1)) begin
                    state_d     = DONE;
                    out_d       = ext_sh[EW-1:2];
                    guard_d     = ext_sh[1];
                    round_d     = ext_sh[0];
                    sticky_d    = acc_q | lost;
                    out_valid_d = 1'b1;
                end
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_q       <= '0;
            amt_q       <= '0;
            stage_q     <= '0;
            acc_q       <= 1'b0;
            out_q       <= '0;
            guard_q     <= 1'b0;
            round_q     <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            amt_q       <= amt_d;
            stage_q     <= stage_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            guard_q     <= guard_d;
            round_q     <= round_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign guard     = guard_q;
    assign round     = round_q;
    assign sticky    = sticky_q;
endmodule

// File: tb/tb_shiftright_sticky_division.sv
// tb_shiftright_sticky_division: randomized and directed checks of the denormalizer
// against a single-shift arithmetic reference model.
module tb_shiftright_sticky_division;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_d = '0;
    logic [4:0]  nsr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_w;
    logic        guard, round, sticky;
    int checks = 0;
    int failures = 0;

    shiftright_sticky_division dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_d),
        .nshiftright(nsr), .out_valid(out_valid), .out_ready(out_ready), .out(out_w),
        .guard(guard), .round(round), .sticky(sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] model(input logic [23:0] d, input int n);
        logic [63:0] e, r;
        e = {38'd0, d, 2'b00};
        r = e >> n;
        return {r[25:2], r[1], r[0], |(e & ((64'd1 << n) - 64'd1))};
    endfunction

    task automatic transact(input logic [23:0] d, input logic [4:0] n, input int stall,
                            output logic [26:0] res, output int lat, output bit stable);
        int w;
        @(negedge clk);
        in_valid = 1'b1; in_d = d; nsr = n;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 1'b0; in_d = 24'($urandom); nsr = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin lat = -1; res = 'x; stable = 1'b0; return; end
        res = {out_w, guard, round, sticky};
        stable = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if ({out_w, guard, round, sticky} !== res || !out_valid) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if ({out_w, guard, round, sticky} !== 27'd0) begin
            failures++;
            $display("FAIL reset_out got=%h required 0", {out_w, guard, round, sticky});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [23:0] din [4] = '{24'h800000, 24'h000003, 24'h800000, 24'hFFFFFF};
        logic [4:0]  nin [4] = '{5'd1, 5'd3, 5'd24, 5'd31};
        logic [26:0] exp [4] = '{{24'h400000, 3'b000}, {24'h0, 3'b011},
                                 {24'h0, 3'b100}, {24'h0, 3'b001}};
        logic [26:0] res; int lat; bit st;
        for (int i = 0; i < 4; i++) begin
            transact(din[i], nin[i], 0, res, lat, st);
            checks++;
            if (res !== exp[i]) begin
                failures++;
                $display("FAIL directed%0d got=%h required=%h", i, res, exp[i]);
            end
            checks++;
            if (lat !== 5) begin
                failures++;
                $display("FAIL latency%0d got=%0d required=5", i, lat);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL release%0d out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_stall();
        logic [26:0] res; int lat; bit ok;
        @(negedge clk);
        in_valid = 1'b1; in_d = 24'hABCDEF; nsr = 5'd0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_d = 24'h123456; nsr = 5'd7;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL stall_latency got=%0d required=5", lat); end
        res = {out_w, guard, round, sticky};
        checks++;
        if (res !== {24'hABCDEF, 3'b000}) begin
            failures++;
            $display("FAIL stall_value got=%h required=%h", res, {24'hABCDEF, 3'b000});
        end
        ok = 1'b1;
        in_valid = 1'b1; in_d = 24'h555555; nsr = 5'd4;
        repeat (4) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_w, guard, round, sticky} !== res) ok = 1'b0;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_hold outputs or handshake changed while stalled, required stable"); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ok = 1'b1;
        repeat (8) begin @(posedge clk); #1; if (out_valid !== 1'b0) ok = 1'b0; end
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_ignored out_valid=1 seen, required no extra result"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        in_valid = 1'b1; in_d = 24'hFFFFFF; nsr = 5'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        ok = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) ok = 1'b0; end
        checks++;
        if (!ok || out_w !== 24'd0) begin
            failures++;
            $display("FAIL reset_stale out_valid seen=%b out=%h required none/0", !ok, out_w);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [26:0] ra, rb; int la, lb; bit ok;
        @(negedge clk);
        in_valid = 1'b1; in_d = 24'hC00000; nsr = 5'd2; out_ready = 1'b1;
        @(posedge clk); #1;
        in_d = 24'h000001; nsr = 5'd1;
        la = 0;
        while (!out_valid && la < 20) begin @(posedge clk); #1; la++; end
        ra = {out_w, guard, round, sticky};
        @(posedge clk); #1;
        ok = (out_valid === 1'b0) && (in_ready === 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lb = 0;
        while (!out_valid && lb < 20) begin @(posedge clk); #1; lb++; end
        rb = {out_w, guard, round, sticky};
        @(posedge clk); #1;
        ok = ok && (out_valid === 1'b0);
        out_ready = 1'b0;
        checks++;
        if (ra !== {24'h300000, 3'b000}) begin failures++; $display("FAIL b2b_first got=%h required=%h", ra, {24'h300000, 3'b000}); end
        checks++;
        if (rb !== {24'h0, 3'b100}) begin failures++; $display("FAIL b2b_second got=%h required=%h", rb, {24'h0, 3'b100}); end
        checks++;
        if (la !== 5 || lb !== 5) begin failures++; $display("FAIL b2b_latency got=%0d/%0d required 5/5", la, lb); end
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_handshake single-cycle valid / idle gap not seen"); end
    endtask

    task automatic test_random();
        logic [26:0] res, exp; int lat; bit st;
        logic [23:0] d; logic [4:0] n; int stall;
        for (int i = 0; i < 40; i++) begin
            d = 24'($urandom);
            if (i % 4 == 0) d = d >> $urandom_range(0, 23);
            n = 5'($urandom_range(0, 31));
            stall = $urandom_range(0, 3);
            exp = model(d, int'(n));
            transact(d, n, stall, res, lat, st);
            checks++;
            if (res !== exp || lat !== 5 || !st) begin
                failures++;
                $display("FAIL random%0d in=%h n=%0d got=%h lat=%0d stable=%b required=%h lat=5 stable=1",
                         i, d, n, res, lat, st, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
